// File: rtl/io_mmio_ctrl_pkg.sv
// Shared constants for the IO MMIO controller: region base, register offsets
// and status bit positions.
package io_mmio_ctrl_pkg;

   localparam logic [31:0] IO_BASE_DEF = 32'h8000_0000;

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_RXDATA = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_CYCLE  = 8'h10;
   localparam logic [7:0] OFF_INSTR  = 8'h14;
   localparam logic [7:0] OFF_CLR    = 8'h18;

   localparam int ST_TX_NFULL  = 0;
   localparam int ST_RX_NEMPTY = 1;
   localparam int ST_TX_OVF    = 2;
   localparam int ST_RX_OVF    = 3;

endpackage

// File: rtl/io_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with registered count; push is refused when full and pop
// when empty, both judged on the state before this cycle's update.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is defined entirely by the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO block: UART TX/RX FIFOs, sticky overflow status and
// cycle/instruction counters, with a registered read port.
module io_mmio_ctrl
   import io_mmio_ctrl_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_din,
   input  logic [3:0]  io_we,
   input  logic        io_re,
   output logic [31:0] io_dout,
   input  logic        inst_retire,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   logic        w_hit;
   logic        w_acc;
   logic        w_wr;
   logic        w_rd;
   logic [7:0]  w_sel;
   logic        w_tx_full, w_tx_empty, w_tx_push_req, w_tx_pop;
   logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
   logic [7:0]  w_rx_head;
   logic        w_tx_ovf_ev, w_rx_ovf_ev;
   logic        w_status_rd;
   logic        w_clr;
   logic [31:0] w_status;
   logic [31:0] w_rd_data;
   logic        w_unused;

   logic        r_tx_ovf;
   logic        r_rx_ovf;
   logic [31:0] r_cyc;
   logic [31:0] r_inst;
   logic [31:0] r_dout;

   assign w_unused = &{1'b0, io_addr[27:8], io_din[31:8]};

   // A simultaneous read and write strobe is handled as a write only.
   assign w_hit = (io_addr[31:28] == IO_BASE[31:28]);
   assign w_sel = io_addr[7:0];
   assign w_acc = ~stall & ~rst;
   assign w_wr  = w_acc & (|io_we);
   assign w_rd  = w_acc & io_re & ~(|io_we);

   assign w_tx_push_req = w_wr & w_hit & (w_sel == OFF_TXDATA);
   assign w_clr         = w_wr & w_hit & (w_sel == OFF_CLR);
   assign w_status_rd   = w_rd & w_hit & (w_sel == OFF_STATUS);
   assign w_rx_pop      = w_rd & w_hit & (w_sel == OFF_RXDATA) & ~w_rx_empty;

   assign uart_tx_valid = ~w_tx_empty;
   assign w_tx_pop      = uart_tx_valid & uart_tx_ready;
   assign uart_rx_ready = ~w_rx_full & ~rst;
   assign w_rx_push     = uart_rx_valid & uart_rx_ready;

   assign w_tx_ovf_ev = w_tx_push_req & w_tx_full;
   assign w_rx_ovf_ev = uart_rx_valid & w_rx_full & ~rst;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tx_push_req),
      .i_pop   (w_tx_pop),
      .i_din   (io_din[7:0]),
      .o_head  (uart_tx_data),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_din   (uart_rx_data),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   always_comb begin
      w_status = '0;
      w_status[ST_TX_NFULL]  = ~w_tx_full;
      w_status[ST_RX_NEMPTY] = ~w_rx_empty;
      w_status[ST_TX_OVF]    = r_tx_ovf;
      w_status[ST_RX_OVF]    = r_rx_ovf;
   end

   always_comb begin
      w_rd_data = '0;
      if (w_hit) begin
         case (w_sel)
            OFF_STATUS: w_rd_data = w_status;
            OFF_RXDATA: w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
            OFF_CYCLE:  w_rd_data = r_cyc;
            OFF_INSTR:  w_rd_data = r_inst;
            default:    w_rd_data = '0;
         endcase
      end
   end

   // A same-cycle overflow event wins over the clear-on-read of status.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_ovf <= 1'b0;
         r_rx_ovf <= 1'b0;
         r_cyc    <= '0;
         r_inst   <= '0;
         r_dout   <= '0;
      end else begin
         r_tx_ovf <= (r_tx_ovf & ~w_status_rd) | w_tx_ovf_ev;
         r_rx_ovf <= (r_rx_ovf & ~w_status_rd) | w_rx_ovf_ev;
         if (w_clr) begin
            r_cyc  <= '0;
            r_inst <= '0;
         end else begin
            r_cyc <= r_cyc + 32'd1;
            if (inst_retire && !stall) r_inst <= r_inst + 32'd1;
         end
         if (w_rd) r_dout <= w_rd_data;
      end
   end

   assign io_dout = r_dout;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl; inputs change and outputs are checked on
// the falling edge, so each check sees the state after the previous rising edge.
module tb_io_mmio_ctrl;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] io_addr;
   logic [31:0] io_din;
   logic [3:0]  io_we;
   logic        io_re;
   logic [31:0] io_dout;
   logic        inst_retire;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   io_mmio_ctrl #(.FIFO_DEPTH(8), .IO_BASE(BASE)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .io_addr       (io_addr),
      .io_din        (io_din),
      .io_we         (io_we),
      .io_re         (io_re),
      .io_dout       (io_dout),
      .inst_retire   (inst_retire),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [7:0] off, input logic [31:0] data);
      io_addr = BASE | {24'd0, off};
      io_din  = data;
      io_we   = 4'hF;
      tick();
      io_we   = 4'h0;
   endtask

   task automatic cpu_read(input logic [7:0] off, input logic [31:0] exp, input string tag);
      io_addr = BASE | {24'd0, off};
      io_re   = 1'b1;
      tick();
      io_re   = 1'b0;
      check(tag, io_dout, exp);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; io_addr = '0; io_din = '0; io_we = '0; io_re = 1'b0;
      inst_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
      @(negedge clk);
      tick(); tick();
      check("rst_dout", io_dout, 32'd0);
      check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
      check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
      rst = 1'b0;
      tick();
      check("rx_ready_after_rst", {31'd0, uart_rx_ready}, 32'd1);
      cpu_read(8'h00, 32'h1, "status_idle");

      // Two TX bytes drained back to back by a ready transmitter
      uart_tx_ready = 1'b1;
      cpu_write(8'h08, 32'h41);
      check("tx_valid_a", {31'd0, uart_tx_valid}, 32'd1);
      check("tx_data_a", {24'd0, uart_tx_data}, 32'h41);
      io_din = 32'h42; io_we = 4'hF;
      tick();
      io_we = 4'h0;
      check("tx_valid_b", {31'd0, uart_tx_valid}, 32'd1);
      check("tx_data_b", {24'd0, uart_tx_data}, 32'h42);
      tick();
      check("tx_valid_idle", {31'd0, uart_tx_valid}, 32'd0);

      // Nine writes into an 8-deep TX FIFO with the transmitter stalled
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) cpu_write(8'h08, 32'h10 + i);
      cpu_read(8'h00, 32'h4, "status_tx_ovf");
      cpu_read(8'h00, 32'h0, "status_ovf_cleared");
      uart_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_drain", {24'd0, uart_tx_data}, 32'h10 + i);
         tick();
      end
      check("tx_dropped_9th", {31'd0, uart_tx_valid}, 32'd0);

      // Single RX byte, then read of an empty RX FIFO
      uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
      tick();
      uart_rx_valid = 1'b0;
      cpu_read(8'h00, 32'h3, "status_rx_nempty");
      cpu_read(8'h04, 32'h5A, "rx_data_5a");
      cpu_read(8'h00, 32'h1, "status_rx_empty");
      cpu_read(8'h04, 32'h0, "rx_empty_read");

      // Fill RX, overflow it with a held valid, free one slot
      uart_rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         uart_rx_data = 8'h60 + 8'(i);
         tick();
      end
      check("rx_ready_full", {31'd0, uart_rx_ready}, 32'd0);
      uart_rx_data = 8'h77;
      tick();
      uart_rx_valid = 1'b0;
      cpu_read(8'h00, 32'hB, "status_rx_ovf");
      cpu_read(8'h04, 32'h60, "rx_head_after_full");
      check("rx_ready_reassert", {31'd0, uart_rx_ready}, 32'd1);
      cpu_read(8'h00, 32'h3, "status_rx_ovf_cleared");

      // Leave two bytes parked in TX for the reset test
      uart_tx_ready = 1'b0;
      cpu_write(8'h08, 32'hAA);
      cpu_write(8'h08, 32'hBB);
      check("tx_parked", {31'd0, uart_tx_valid}, 32'd1);

      // Counters: clear, then 10 retires with 3 of them stalled
      cpu_write(8'h18, 32'h0);
      cpu_read(8'h10, 32'd0, "cycle_after_clr");
      cpu_read(8'h10, 32'd1, "cycle_next");
      cpu_write(8'h18, 32'h0);
      inst_retire = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stall = (i >= 3 && i < 6);
         tick();
      end
      stall = 1'b0; inst_retire = 1'b0;
      cpu_read(8'h14, 32'd7, "instr_count_7");
      cpu_write(8'h18, 32'h0);
      cpu_read(8'h14, 32'd0, "instr_after_clr");
      cpu_read(8'h10, 32'd1, "cycle_after_clr2");
      inst_retire = 1'b1;
      tick();
      inst_retire = 1'b0;
      cpu_read(8'h14, 32'd1, "instr_incr");
      stall = 1'b1;
      cpu_read(8'h10, 32'd1, "dout_hold_stall");
      stall = 1'b0;

      // Reset with both FIFOs partially full
      rst = 1'b1;
      tick(); tick();
      check("rst2_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
      check("rst2_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
      check("rst2_dout", io_dout, 32'd0);
      rst = 1'b0;
      cpu_read(8'h10, 32'd0, "cycle_after_rst");
      check("tx_valid_after_rst", {31'd0, uart_tx_valid}, 32'd0);
      cpu_read(8'h00, 32'h1, "status_after_rst");
      cpu_read(8'h14, 32'd0, "instr_after_rst");
      cpu_read(8'h04, 32'd0, "rx_empty_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_mmio_ctrl.md
IO_MMIO_CTRL -- requirements
Module: io_mmio_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per UART FIFO; power of two, minimum 2.
REQ-002 Parameter IO_BASE, default 32'h8000_0000, base of the IO address region.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  processor stall; freezes CPU-side accesses and the instruction counter.
REQ-006 io_addr  in  32  byte address from the execute stage ALU result.
REQ-007 io_din  in  32  store data, already lane-shifted.
REQ-008 io_we  in  4  byte write enables; any bit set is a write.
REQ-009 io_re  in  1  read strobe.
REQ-010 io_dout  out  32  registered read data for the writeback stage.
REQ-011 inst_retire  in  1  one non-NOP instruction leaves the execute stage this cycle.
REQ-012 uart_tx_data  out  8  byte to the UART transmitter.
REQ-013 uart_tx_valid  out  1  uart_tx_data is valid.
REQ-014 uart_tx_ready  in  1  transmitter accepts the byte this cycle.
REQ-015 uart_rx_data  in  8  byte from the UART receiver.
REQ-016 uart_rx_valid  in  1  uart_rx_data is valid.
REQ-017 uart_rx_ready  out  1  block accepts the received byte this cycle.

Function
REQ-018 Hit: io_addr[31:28]==IO_BASE[31:28]; the register is selected by io_addr[7:0]; non-hits are ignored and read as 0.
REQ-019 Map:
- 0x00 status (R): bit0 TX not full; bit1 RX not empty; bit2 TX overflow (sticky); bit3 RX overflow (sticky); other bits 0.
- 0x04 RX data (R): {24'b0, head byte}; the read pops the FIFO.
- 0x08 TX data (W): pushes io_din[7:0].
- 0x10 cycle counter (R).
- 0x14 instruction counter (R).
- 0x18 (W): clears both counters.
REQ-020 CPU accesses take effect only when stall==0; io_re and io_we together at one address are treated as a write only.
REQ-021 io_dout updates one cycle after an accepted read; it holds its value when there is no accepted read or when stall==1.
REQ-022 A reading of status clears both overflow bits on the next cycle; an overflow event in the same cycle sets its bit again.
REQ-023 TX push when full: byte dropped, TX overflow set; "full" is sampled before any same-cycle pop, so push plus pop on a full FIFO still drops.
REQ-024 uart_tx_valid = TX FIFO not empty; uart_tx_data = TX head; pop when valid && uart_tx_ready.
REQ-025 uart_rx_ready = RX FIFO not full and rst==0; push when uart_rx_valid && uart_rx_ready.
REQ-026 RX overflow sets when uart_rx_valid==1 while the RX FIFO is full.
REQ-027 RX read when empty: returns 0, pointers unchanged; a same-cycle push into an empty FIFO is not visible to that read.
REQ-028 Simultaneous push and pop on a non-full, non-empty FIFO: both succeed and the count is unchanged.
REQ-029 Pointers wrap modulo FIFO_DEPTH; the count width is log2(FIFO_DEPTH)+1.
REQ-030 Cycle counter: 32-bit, +1 every non-reset cycle regardless of stall, wraps at 2^32.
REQ-031 Instruction counter: 32-bit, +1 when inst_retire && !stall, wraps.
REQ-032 A counter clear write forces both counters to 0 that cycle, taking priority over increment; the counters read 0 and 1 on the following cycles.

Reset
REQ-033 While rst==1:
- FIFO pointers and counts are 0.
- Overflow bits, both counters and io_dout are 0.
- uart_tx_valid and uart_rx_ready are 0.
- CPU accesses and UART handshakes are ignored.
REQ-034 Reset asserted mid-transfer discards FIFO contents; there is no partial byte state.

Structure
REQ-035 Shared package holds IO_BASE, the register offsets (0x00, 0x04, 0x08, 0x10, 0x14, 0x18) and the status bit indices.
REQ-036 One sub-module, sync_fifo (width 8, depth FIFO_DEPTH), instantiated twice (TX, RX); it exposes full, empty, push, pop and head data.

Verification
REQ-037 Write TX at 0x08 with 0x41, 0x42 and uart_tx_ready=1 -> uart_tx_data 0x41 then 0x42, one each, then uart_tx_valid=0.
REQ-038 uart_tx_ready=0, 9 TX writes -> 8 bytes held, status reads 0x4 (bit0=0, bit2=1); a second status read returns bit2=0.
REQ-039 Inject 0x5A on RX; read 0x00 then 0x04 -> status bit1=1, io_dout=0x5A one cycle later; next status bit1=0; empty RX read -> 0.
REQ-040 RX FIFO full -> uart_rx_ready=0; a held uart_rx_valid sets bit3; one RX read reasserts uart_rx_ready next cycle.
REQ-041 Retire 10 instructions with stall high for 3 of them -> instruction counter 7; write 0x18 -> both counters read 0 then increment.
REQ-042 Assert rst with both FIFOs partially full -> uart_tx_valid=0, status 0x1, counters 0 on the cycle after reset releases.
